shift_add_multiplier_8: RTL and testbench
=========================================

SHIFT_ADD_MULTIPLIER_8 -- requirements
Module: shift_add_multiplier_8

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block can accept an operand pair; high only in IDLE.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  product valid; high only in DONE.
REQ-009 out_ready  input  1  consumer takes product.
REQ-010 product  output  16  unsigned a*b, registered.
REQ-011 busy  output  1  high only in RUN.

Function
REQ-012 Internal registers SHALL be: state (IDLE/RUN/DONE), m[7:0], acc[7:0] (product high), q[7:0] (multiplier/product low), cnt[2:0].
REQ-013 in_ready, out_valid, busy SHALL decode state combinationally; product SHALL equal {acc,q}.
REQ-014 IDLE: on edge with in_valid=1, SHALL load m<=a, q<=b, acc<=0, cnt<=0, go RUN; in_valid=0 -> stay IDLE, registers unchanged.
REQ-015 a/b SHALL be sampled only at the accept edge; later changes SHALL have no effect.
REQ-016 RUN, each edge: 9-bit {c,s} = q[0] ? acc+m : {1'b0,acc} (8-bit add, carry-in 0); then {acc,q} <= {c,s,q[7:1]}; cnt<=cnt+1.
REQ-017 RUN SHALL last exactly 8 edges; on the edge where cnt==7, go DONE.
REQ-018 Latency: accept at edge N -> out_valid high immediately after edge N+8 with product=a*b.
REQ-019 Addition carry SHALL never be lost; 0xFF*0xFF SHALL yield 0xFE01.
REQ-020 DONE: product and out_valid SHALL hold stable while out_ready=0, indefinitely.
REQ-021 DONE with out_ready=1 at an edge: go IDLE; product SHALL keep the last result in IDLE until next accept.
REQ-022 in_valid SHALL be ignored in RUN and DONE (in_ready=0); no operand is queued.
REQ-023 Minimum spacing between accepts SHALL be 10 edges (accept, 8 RUN, 1 DONE with out_ready=1).
REQ-024 product SHALL be checked only when out_valid=1; intermediate RUN values are not part of the contract.

Reset
REQ-025 Edge with rst_n=0 SHALL force state=IDLE and m, acc, q, cnt=0, from any state, including mid-RUN and in DONE; in-flight operation discarded.
REQ-026 Reset SHALL take priority over in_valid and out_ready on the same edge; no accept on a reset edge.
REQ-027 After reset edge: in_ready=1, out_valid=0, busy=0, product=0x0000.
REQ-028 Output values before the first reset edge are undefined; bench SHALL apply rst_n=0 for at least 2 edges.

Verification
REQ-029 Accept a=0x0D, b=0x0B at edge N, out_ready=1 -> busy high edges N+1..N+8, out_valid after N+8, product=0x008F, in_ready high after N+9.
REQ-030 Corners: 0x00*0xFF -> 0x0000; 0xFF*0xFF -> 0xFE01; 0x80*0x02 -> 0x0100; 0x01*0xFF -> 0x00FF.
REQ-031 Backpressure: 0x12*0x34, out_ready=0 for 5 cycles after out_valid -> product stays 0x03A8, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-032 Reset mid-RUN after 4 iterations -> next edge IDLE, product=0x0000, out_valid never asserted; following 0x07*0x09 -> 0x003F.
REQ-033 in_valid held high with changing a/b -> products match only the pairs present on accept edges, accepts exactly 10 edges apart with out_ready=1.
REQ-034 Random: 1000 random a/b with random out_ready stalls -> every product equals a*b against reference model.

Source files
------------

// File: rtl/shift_add_multiplier_8_if.sv
// Operand/product handshake bundle for the 8x8 shift-add multiplier.
// The master side supplies operands and consumes products; the slave side is the multiplier.
interface shift_add_multiplier_8_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/shift_add_multiplier_8.sv
// Sequential 8x8 unsigned multiplier: one shift-add step per clock, eight steps per product.
// The product is held in {acc, q} from DONE until the next operand pair is accepted.
module shift_add_multiplier_8 (
    input  logic                           clk,
    input  logic                           rst_n,
    shift_add_multiplier_8_if.slave        bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] m_q, m_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic [8:0] sum;

    // 9-bit sum keeps the carry, which becomes the new top bit of acc after the shift.
    always_comb begin
        sum = q_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {1'b0, acc_q};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    acc_d   = 8'd0;
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                {acc_d, q_d} = {sum, q_q[7:1]};
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= 8'd0;
            acc_q   <= 8'd0;
            q_q     <= 8'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q == RUN);
        bus.out_valid = (state_q == DONE);
        bus.product   = {acc_q, q_q};
    end

endmodule

// File: tb/tb_shift_add_multiplier_8.sv
// Scoreboard bench for shift_add_multiplier_8: the driver queues a*b at each accept,
// an independent monitor checks product and latency whenever out_valid is seen.
module tb_shift_add_multiplier_8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mode = 0;  // 0: always ready, 1: random stalls, 2: never ready
    bit   seen = 1'b0;

    logic [15:0] exp_q[$];
    int          acc_q[$];

    shift_add_multiplier_8_if bus ();

    shift_add_multiplier_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present a pair and hold it until accepted; returns just after the accept edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = ia;
        bus.b        = ib;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back({8'd0, ia} * {8'd0, ib});
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_pending required=0_pending", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares every cycle out_valid is high, so DONE stability is checked too.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid actual=valid product=%h required=no_valid",
                             bus.product);
                end else begin
                    chk("product", bus.product, exp_q[0]);
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 16'(cyc - acc_q[0]), 16'd8);
                    end
                end
            end
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
            if (bus.out_valid === 1'b1 && bus.out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 8'd0;
        bus.b        = 8'd0;
        mode         = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_product", bus.product, 16'h0000);
        rst_n = 1'b1;

        // 0x0D * 0x0B with timing of busy/out_valid/in_ready
        issue(8'h0D, 8'h0B);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("run_busy", 16'(bus.busy), 16'd1);
            chk("run_no_valid", 16'(bus.out_valid), 16'd0);
        end
        @(negedge clk);
        chk("done_valid", 16'(bus.out_valid), 16'd1);
        chk("done_busy", 16'(bus.busy), 16'd0);
        chk("done_in_ready", 16'(bus.in_ready), 16'd0);
        chk("done_product", bus.product, 16'h008F);
        @(negedge clk);
        chk("idle_in_ready", 16'(bus.in_ready), 16'd1);
        chk("idle_hold_product", bus.product, 16'h008F);
        wait_drain();

        // corners
        issue(8'h00, 8'hFF);
        issue(8'hFF, 8'hFF);
        issue(8'h80, 8'h02);
        issue(8'h01, 8'hFF);
        wait_drain();

        // backpressure with ignored in_valid pulses
        mode = 2;
        issue(8'h12, 8'h34);
        repeat (9) @(negedge clk);
        chk("bp_valid", 16'(bus.out_valid), 16'd1);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
            chk("bp_hold_valid", 16'(bus.out_valid), 16'd1);
            chk("bp_hold_product", bus.product, 16'h03A8);
        end
        bus.in_valid = 1'b0;
        mode = 0;
        repeat (2) @(negedge clk);
        chk("bp_release_idle", 16'(bus.in_ready), 16'd1);
        wait_drain();

        // reset after four RUN iterations, with in_valid high on the reset edge
        issue(8'h55, 8'h33);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 16'(bus.in_ready), 16'd1);
        chk("midrst_busy", 16'(bus.busy), 16'd0);
        chk("midrst_valid", 16'(bus.out_valid), 16'd0);
        chk("midrst_product", bus.product, 16'h0000);
        exp_q.delete();
        acc_q.delete();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        issue(8'h07, 8'h09);
        wait_drain();
        chk("after_rst_product", bus.product, 16'h003F);

        // in_valid held high with operands changing every cycle
        @(negedge clk);
        last = -1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            if (bus.in_ready) begin
                exp_q.push_back({8'd0, bus.a} * {8'd0, bus.b});
                acc_q.push_back(cyc + 1);
                if (last >= 0) chk("accept_spacing", 16'(cyc + 1 - last), 16'd10);
                last = cyc + 1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_drain();

        // random operands with random consumer stalls
        mode = 1;
        for (int i = 0; i < 1000; i++) begin
            issue(8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        mode = 0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
